// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bundle between the fetch sequencer and instruction memory.
interface pc_fetch_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: steers the PC load port, handshakes with instruction memory, registers instructions for decode.
// Optional trap redirect with exception-PC capture is enabled by defining PC_TRAP_EN.
module pc_fetch_ctrl #(
  parameter int            AW        = 16,
  parameter int            DW        = 16,
  parameter logic [AW-1:0] RESET_VEC = 16'h0000,
  parameter logic [AW-1:0] TRAP_VEC  = 16'h0004
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          pc_load,
  output logic [AW-1:0] pc_in,
  pc_fetch_ctrl_if.master imem,
  input  logic          stall,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          halt,
`ifdef PC_TRAP_EN
  input  logic          trap,
  output logic [AW-1:0] epc,
`endif
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] instr_pc,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t        cur_state;
  state_t        next_state;
  logic          active;
  logic          redirect;
  logic [AW-1:0] redirect_target;
  logic          accept;

  assign active = (cur_state == FETCH) || (cur_state == WAIT);
  assign state  = cur_state;

  // Redirect sources in priority order; any of them squashes the in-flight fetch.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = pc;
    if (active) begin
`ifdef PC_TRAP_EN
      if (trap) begin
        redirect        = 1'b1;
        redirect_target = TRAP_VEC;
      end else
`endif
      if (jump) begin
        redirect        = 1'b1;
        redirect_target = jump_target;
      end else if (branch_taken) begin
        redirect        = 1'b1;
        redirect_target = branch_target;
      end
    end
  end

  assign accept = active && !redirect && !halt && imem.imem_ack && !stall;

  always_ff @(posedge clk) begin
    if (!reset) cur_state <= BOOT;
    else        cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      BOOT:        next_state = FETCH;
      FETCH, WAIT: begin
        if (redirect)           next_state = FETCH;
        else if (halt)          next_state = HALTED;
        else if (imem.imem_ack) next_state = FETCH;
        else                    next_state = WAIT;
      end
      HALTED:      next_state = HALTED;
      default:     next_state = BOOT;
    endcase
  end

  // The PC holds by reloading itself; only an accepted fetch lets it increment.
  always_comb begin
    pc_load        = 1'b1;
    pc_in          = pc;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    case (cur_state)
      BOOT:        pc_in = RESET_VEC;
      FETCH, WAIT: begin
        if (redirect) begin
          imem.imem_req = 1'b1;
          pc_in         = redirect_target;
        end else if (!halt) begin
          imem.imem_req = 1'b1;
          if (imem.imem_ack && !stall) pc_load = 1'b0;
        end
      end
      default:     pc_in = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else begin
      instr_valid <= accept;
      if (accept) begin
        instr    <= imem.imem_rdata;
        instr_pc <= pc;
      end
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge clk) begin
    if (!reset)              epc <= '0;
    else if (active && trap) epc <= pc;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench: a PC register model feeds the sequencer, a scoreboard checks every delivered instruction.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc = 16'h0000;
  logic        pc_load;
  logic [15:0] pc_in;
  logic        stall, jump, branch_taken, halt;
  logic [15:0] jump_target, branch_target;
  logic [15:0] instr, instr_pc;
  logic        instr_valid;
  logic [1:0]  state;
`ifdef PC_TRAP_EN
  logic        trap = 1'b0;
  logic [15:0] epc;
`endif

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pc_fetch_ctrl_if #(.AW(16), .DW(16)) imem ();

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_load(pc_load), .pc_in(pc_in),
    .imem(imem), .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
`ifdef PC_TRAP_EN
    .trap(trap), .epc(epc),
`endif
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .state(state)
  );

  always #5 clk = ~clk;

  // Program counter register the sequencer steers: load when asked, otherwise count up.
  always @(posedge clk) begin
    if (pc_load === 1'b1) pc <= pc_in;
    else                  pc <= pc + 16'd1;
  end

  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_fetch got instr=%h instr_pc=%h required no instr_valid", instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc) begin
          failures++;
          $display("[TB] FAIL fetch got instr=%h instr_pc=%h required instr=%h instr_pc=%h",
                   instr, instr_pc, e.instr, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic ack, input logic [15:0] rdata, input logic stl,
                               input logic jmp, input logic [15:0] jt, input logic br,
                               input logic [15:0] bt, input logic hlt);
    imem.imem_ack   = ack;
    imem.imem_rdata = rdata;
    stall           = stl;
    jump            = jmp;
    jump_target     = jt;
    branch_taken    = br;
    branch_target   = bt;
    halt            = hlt;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got %h required %h", name, actual, expected);
    end
  endtask

  task automatic expectFetch(input logic [15:0] i, input logic [15:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_valid", 16'(instr_valid), 16'h0);
      checkOutput("rst_state", 16'(state), 16'h0);
      checkOutput("rst_pc_load", 16'(pc_load), 16'h1);
    end
    checkOutput("rst_instr", instr, 16'h0000);
    checkOutput("rst_instr_pc", instr_pc, 16'h0000);

    reset = 1'b1;
    #1;
    checkOutput("boot_state", 16'(state), 16'h0);
    checkOutput("boot_pc_load", 16'(pc_load), 16'h1);
    checkOutput("boot_pc_in", pc_in, 16'h0000);
    checkOutput("boot_req", 16'(imem.imem_req), 16'h0);
    @(negedge clk);

    // Zero-wait memory: one accepted instruction per cycle at 0..4.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 16'(16'h00A0 + i), 0, 0, 16'h0000, 0, 16'h0000, 0);
      checkOutput("zw_addr", imem.imem_addr, 16'(i));
      checkOutput("zw_req", 16'(imem.imem_req), 16'h1);
      checkOutput("zw_pc_load", 16'(pc_load), 16'h0);
      expectFetch(16'(16'h00A0 + i), 16'(i));
      @(negedge clk);
    end

    // Slow memory at pc=5: three cycles without ack, PC must hold.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0);
      checkOutput("wait_pc_load", 16'(pc_load), 16'h1);
      checkOutput("wait_pc_in", pc_in, 16'h0005);
      checkOutput("wait_req", 16'(imem.imem_req), 16'h1);
      checkOutput("wait_addr", imem.imem_addr, 16'h0005);
      @(negedge clk);
    end
    checkOutput("wait_state", 16'(state), 16'h2);
    applyStimulus(1, 16'h00C5, 0, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("wait_ack_pc_load", 16'(pc_load), 16'h0);
    expectFetch(16'h00C5, 16'h0005);
    @(negedge clk);

    // Jump and branch together with an ack: jump wins, fetch squashed.
    applyStimulus(1, 16'hDEAD, 0, 1, 16'h0040, 1, 16'h0020, 0);
    checkOutput("jmp_pc_load", 16'(pc_load), 16'h1);
    checkOutput("jmp_pc_in", pc_in, 16'h0040);
    @(negedge clk);
    applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("jmp_squash_valid", 16'(instr_valid), 16'h0);
    checkOutput("jmp_addr", imem.imem_addr, 16'h0040);
    checkOutput("jmp_state", 16'(state), 16'h1);

    // Branch alone to 10, then a stalled ack that must be dropped and refetched.
    applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h000A, 0);
    checkOutput("br_pc_in", pc_in, 16'h000A);
    @(negedge clk);
    applyStimulus(1, 16'h00E0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("stall_pc_load", 16'(pc_load), 16'h1);
    checkOutput("stall_pc_in", pc_in, 16'h000A);
    @(negedge clk);
    applyStimulus(1, 16'h00E1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("stall_drop_valid", 16'(instr_valid), 16'h0);
    checkOutput("refetch_addr", imem.imem_addr, 16'h000A);
    checkOutput("refetch_pc_load", 16'(pc_load), 16'h0);
    expectFetch(16'h00E1, 16'h000A);
    @(negedge clk);
    applyStimulus(0, 16'h0000, 0, 1, 16'hFFFF, 0, 16'h0000, 0);
    checkOutput("after_stall_addr", imem.imem_addr, 16'h000B);
    @(negedge clk);

    // Fetch at the top of the address space wraps the PC to zero.
    applyStimulus(1, 16'h00F0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("wrap_addr", imem.imem_addr, 16'hFFFF);
    expectFetch(16'h00F0, 16'hFFFF);
    @(negedge clk);
    applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("wrap_pc", pc, 16'h0000);

    // Halt beats a simultaneous ack; redirects are ignored afterwards.
    applyStimulus(1, 16'h0BAD, 0, 0, 16'h0000, 0, 16'h0000, 1);
    checkOutput("halt_req", 16'(imem.imem_req), 16'h0);
    checkOutput("halt_pc_load", 16'(pc_load), 16'h1);
    checkOutput("halt_pc_in", pc_in, 16'h0000);
    @(negedge clk);
    applyStimulus(0, 16'h0000, 0, 1, 16'h0040, 1, 16'h0020, 0);
    checkOutput("halted_state", 16'(state), 16'h3);
    checkOutput("halted_req", 16'(imem.imem_req), 16'h0);
    checkOutput("halted_pc_in", pc_in, 16'h0000);
    checkOutput("halted_valid", 16'(instr_valid), 16'h0);
    @(negedge clk);
    checkOutput("halted_stay", 16'(state), 16'h3);
    checkOutput("halted_pc", pc, 16'h0000);

    // Reset recovers from HALTED, then a reset during a fetch drops a late ack.
    reset = 1'b0;
    applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0);
    @(negedge clk);
    checkOutput("rerst_state", 16'(state), 16'h0);
    reset = 1'b1;
    #1;
    @(negedge clk);
    checkOutput("reboot_state", 16'(state), 16'h1);
    checkOutput("reboot_addr", imem.imem_addr, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 16'h0077, 0, 0, 16'h0000, 0, 16'h0000, 0);
    @(negedge clk);
    checkOutput("late_ack_state", 16'(state), 16'h0);
    checkOutput("late_ack_valid", 16'(instr_valid), 16'h0);
    checkOutput("late_ack_instr", instr, 16'h0000);
    @(negedge clk);
    checkOutput("late_ack_valid2", 16'(instr_valid), 16'h0);
    reset = 1'b1;
    applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0);
    @(negedge clk);
    checkOutput("post_rst_state", 16'(state), 16'h1);
    checkOutput("post_rst_addr", imem.imem_addr, 16'h0000);

    repeat (2) @(negedge clk);
    checkOutput("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer that drives the program counter's load port (pc_load/pc_in) and the instruction-memory request handshake.
- Holds the PC while memory is busy or the pipeline stalls; redirects it on jump/branch; latches the fetched instruction for decode.
- Sits between the PC register, instruction memory and decode/execute.

Parameters:
- AW, 16, PC/address width; matches the PC register width.
- DW, 16, instruction width.
- RESET_VEC, 16'h0000, address of the first fetch after reset.
- TRAP_VEC, 16'h0004, trap handler address (used only with PC_TRAP_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pc  in  AW  current PC register value.
- pc_load  out  1  PC load strobe.
- pc_in  out  AW  value the PC loads when pc_load=1.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address.
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- imem_rdata  in  DW  fetched instruction.
- stall  in  1  decode cannot accept a new instruction.
- jump  in  1  unconditional redirect.
- jump_target  in  AW  jump destination.
- branch_taken  in  1  taken branch.
- branch_target  in  AW  branch destination.
- halt  in  1  stop fetching.
- instr  out  DW  registered instruction to decode.
- instr_valid  out  1  instr holds a valid instruction.
- instr_pc  out  AW  address of instr.
- state  out  2  FSM state (debug).

Behaviour:
- reset=0 at a rising edge:
  - state=BOOT; pc_load=1; pc_in=RESET_VEC; imem_req=0; instr=0; instr_valid=0; instr_pc=0.
  - Reset asserted mid-fetch abandons the request; a late imem_ack is ignored.
- State encoding: BOOT=0, FETCH=1, WAIT=2, HALTED=3.
- BOOT: one cycle; forces pc_load with RESET_VEC; next state FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - pc_load=1 with pc_in=pc, so the PC holds.
  - No ack: next state WAIT.
  - Ack in the same cycle (zero-wait memory): handled as in WAIT.
- WAIT:
  - imem_req=1 and imem_addr=pc until imem_ack; PC held.
  - On ack with stall=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1; pc_load=0, so the PC increments by 1 (wrap-around 16'hFFFF->0 is permitted); next state FETCH.
  - On ack with stall=1: instruction dropped, PC held, refetch (next state FETCH).
- instr_valid is a one-cycle pulse per accepted fetch; instr and instr_pc hold their values otherwise.
- Redirect, evaluated every cycle in FETCH/WAIT, priority jump > branch_taken:
  - pc_load=1, pc_in=target.
  - Any in-flight fetch is squashed: an ack in the same cycle does not set instr_valid.
  - instr_valid forced 0 next cycle; next state FETCH.
  - Redirect wins over stall and over ack.
- stall=1 without ack or redirect: PC held, imem_req stays asserted.
- halt=1 (lower priority than redirect, higher than ack):
  - Next state HALTED; imem_req=0; PC held.
  - Stays in HALTED until reset; jump/branch are ignored in HALTED.
- Combinational outputs: pc_load, pc_in, imem_req, imem_addr.
- Registered outputs: instr, instr_valid, instr_pc, state.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined:
  - Adds input trap (1) and output epc (AW).
  - trap=1 in FETCH/WAIT has highest redirect priority: epc<=pc, pc_in=TRAP_VEC, pc_load=1, in-flight fetch squashed.
  - epc resets to 0.
- Undefined: no trap/epc ports, no trap logic.

Test Plan:
- Reset low 3 cycles, then high -> pc_load=1, pc_in=16'h0000 in BOOT; first imem_addr=16'h0000; instr_valid=0 throughout reset.
- Zero-wait memory, instructions A0,A1,A2 at 0,1,2 -> instr_valid pulses with instr_pc=0,1,2; PC advances by 1 per accepted fetch.
- imem_ack delayed 3 cycles at pc=5 -> pc held at 5 for all wait cycles (pc_load=1, pc_in=5); then instr_pc=5 and pc=6.
- jump=1 (target 16'h0040) together with branch_taken=1 (target 16'h0020) and imem_ack=1 -> pc_in=16'h0040; no instr_valid for the squashed fetch; next imem_addr=16'h0040.
- stall=1 during ack at pc=10 -> no instr_valid; refetch from 10; stall released -> instr_pc=10.
- pc=16'hFFFF fetch accepted -> pc wraps to 0; halt=1 -> imem_req=0, state=3, jump ignored until reset.
